apb_mem_arbiter: RTL and testbench

- Round-robin controller that shares the single-port APB-style memory slave (DEPTH x WIDTH) between NUM_REQ requesters.
- Accepts one request at a time, range-checks the address and sequences a single-cycle valid pulse into the slave.
- Waits for the slave's registered ready, with a timeout, then returns a per-requester response pulse carrying read data and error status.
- Sits between the requester masters and the memory slave.

---
 rtl/apb_mem_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/apb_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_apb_mem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types, default geometry and round-robin helper for the APB memory
// arbiter and the memory slave it fronts.
package apb_mem_pkg;

  localparam int unsigned DEF_DEPTH      = 64;
  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
    return (ptr + 1) % num_req;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or above ptr_i,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   gnt_idx_o,
  output logic               any_gnt_o
);

  always_comb begin
    int unsigned idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr_i) + off) % NUM_REQ;
      if (!any_gnt_o && req_i[PTR_W'(idx)]) begin
        gnt_o[PTR_W'(idx)] = 1'b1;
        gnt_idx_o          = PTR_W'(idx);
        any_gnt_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Round-robin front end sharing one single-port APB-style memory slave between
// NUM_REQ requesters, with address range check and ready timeout.
module apb_mem_arbiter
  import apb_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_wr_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [WIDTH-1:0]              rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          m_valid_o,
  output logic                          m_wr_rd_o,
  output logic [ADDR_WIDTH-1:0]         m_addr_o,
  output logic [WIDTH-1:0]              m_wdata_o,
  input  logic                          m_ready_i,
  input  logic [WIDTH-1:0]              m_rdata_i
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  state_e                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           gnt_q, gnt_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    m_wr_q, m_wr_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [WIDTH-1:0]        m_wdata_q, m_wdata_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [PW-1:0]           arb_idx;
  logic                    arb_any;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [WIDTH-1:0]        sel_wdata;
  logic                    sel_oor;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_rr_arbiter (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_gnt_o (arb_any)
  );

  assign sel_wr    = req_wr_i[arb_idx];
  assign sel_addr  = req_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata_i[arb_idx*WIDTH +: WIDTH];
  assign sel_oor   = (32'(sel_addr) >= DEPTH);

  // Response registers are loaded on the transition into RESP, so the pulse
  // is registered yet still lands in the RESP cycle itself.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    tmo_d       = tmo_q;
    m_wr_d      = m_wr_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d = arb_idx;
          if (sel_oor) begin
            rsp_valid_d[arb_idx] = 1'b1;
            rsp_err_d            = 1'b1;
            rsp_rdata_d          = '0;
            state_d              = RESP;
          end else begin
            m_wr_d    = sel_wr;
            m_addr_d  = sel_addr;
            m_wdata_d = sel_wdata;
            state_d   = ACCESS;
          end
        end
      end
      ACCESS: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (m_ready_i) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_err_d          = 1'b0;
          rsp_rdata_d        = m_wr_q ? '0 : m_rdata_i;
          state_d            = RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_err_d          = 1'b1;
          rsp_rdata_d        = '0;
          state_d            = RESP;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d   = PW'(rr_next(32'(gnt_q), NUM_REQ));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      tmo_q       <= '0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      tmo_q       <= tmo_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = (rst_ni && state_q == IDLE) ? arb_gnt : '0;
  assign m_valid_o   = (state_q == ACCESS);
  assign m_wr_rd_o   = m_wr_q;
  assign m_addr_o    = m_addr_q;
  assign m_wdata_o   = m_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Directed bench for apb_mem_arbiter with a small registered-ready memory slave.
module tb_apb_mem_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned AW  = 8;
  localparam int unsigned W   = 16;
  localparam int unsigned DEP = 64;
  localparam int unsigned TMO = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NR-1:0]     req_valid_i = '0;
  logic [NR-1:0]     req_wr_i = '0;
  logic [NR*AW-1:0]  req_addr_i = '0;
  logic [NR*W-1:0]   req_wdata_i = '0;
  logic [NR-1:0]     req_ready_o;
  logic [NR-1:0]     rsp_valid_o;
  logic [W-1:0]      rsp_rdata_o;
  logic              rsp_err_o;
  logic              m_valid_o;
  logic              m_wr_rd_o;
  logic [AW-1:0]     m_addr_o;
  logic [W-1:0]      m_wdata_o;
  logic              m_ready_i;
  logic [W-1:0]      m_rdata_i;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Slave model: ready one cycle after valid; words read back as stored ^ {a,a},
  // giving an address-dependent background with word 0 reading as zero.
  logic [W-1:0] smem [256] = '{default: '0};
  logic         s_rdy_q = 1'b0;
  logic [W-1:0] s_rdata_q = '0;
  logic         slave_en = 1'b1;
  int           mv_cnt = 0;

  always @(posedge clk_i) begin
    s_rdy_q <= m_valid_o & slave_en;
    if (m_valid_o) begin
      mv_cnt <= mv_cnt + 1;
      if (m_wr_rd_o) smem[m_addr_o] <= m_wdata_o ^ {m_addr_o, m_addr_o};
      else           s_rdata_q      <= smem[m_addr_o] ^ {m_addr_o, m_addr_o};
    end
  end

  assign m_ready_i = s_rdy_q;
  assign m_rdata_i = s_rdata_q;

  always #5 clk_i = ~clk_i;

  apb_mem_arbiter #(
    .NUM_REQ    (NR),
    .DEPTH      (DEP),
    .WIDTH      (W),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_wr_i    (req_wr_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .m_valid_o   (m_valid_o),
    .m_wr_rd_o   (m_wr_rd_o),
    .m_addr_o    (m_addr_o),
    .m_wdata_o   (m_wdata_o),
    .m_ready_i   (m_ready_i),
    .m_rdata_i   (m_rdata_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_req(input int n, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_wr_i[n]            = wr;
    req_addr_i[n*AW +: AW] = a;
    req_wdata_i[n*W +: W]  = d;
  endtask

  task automatic apply_reset();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    req_valid_i = '1;
    req_wr_i    = '1;
    req_addr_i  = '1;
    #3;
    vec_cnt++;
    if ({m_valid_o, m_wr_rd_o, m_addr_o, m_wdata_o} !== 26'h0) begin
      err_cnt++;
      $display("FAIL reset_master: got %b/%b/%h/%h want 0", m_valid_o, m_wr_rd_o, m_addr_o, m_wdata_o);
    end
    vec_cnt++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== 21'h0) begin
      err_cnt++;
      $display("FAIL reset_rsp: got %b/%b/%h want 0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    vec_cnt++;
    if (req_ready_o !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_ready: got %b want 0000", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    req_wr_i    = '0;
    req_addr_i  = '0;
    rst_ni      = 1'b1;
  endtask

  task automatic test_write_read();
    tick();
    set_req(0, 1'b1, 8'd5, 16'hA5A5);
    req_valid_i = 4'b0001;
    #1;
    vec_cnt++;
    if (req_ready_o !== 4'b0001) begin
      err_cnt++;
      $display("FAIL wr_accept: got %b want 0001", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    #1;
    vec_cnt++;
    if ({m_valid_o, m_wr_rd_o, m_addr_o, m_wdata_o} !== {1'b1, 1'b1, 8'd5, 16'hA5A5}) begin
      err_cnt++;
      $display("FAIL wr_access: got %b/%b/%h/%h want 1/1/05/a5a5", m_valid_o, m_wr_rd_o, m_addr_o, m_wdata_o);
    end
    tick();
    #1;
    vec_cnt++;
    if ({m_valid_o, m_addr_o, rsp_valid_o} !== {1'b0, 8'd5, 4'b0000}) begin
      err_cnt++;
      $display("FAIL wr_wait: got %b/%h/%b want 0/05/0000", m_valid_o, m_addr_o, rsp_valid_o);
    end
    tick();
    #1;
    vec_cnt++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'b0001, 1'b0, 16'h0000}) begin
      err_cnt++;
      $display("FAIL wr_rsp: got %b/%b/%h want 0001/0/0000", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    tick();
    set_req(0, 1'b0, 8'd5, 16'h0000);
    req_valid_i = 4'b0001;
    #1;
    vec_cnt++;
    if (req_ready_o !== 4'b0001) begin
      err_cnt++;
      $display("FAIL rd_accept: got %b want 0001", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    #1;
    vec_cnt++;
    if ({m_valid_o, m_wr_rd_o, m_addr_o} !== {1'b1, 1'b0, 8'd5}) begin
      err_cnt++;
      $display("FAIL rd_access: got %b/%b/%h want 1/0/05", m_valid_o, m_wr_rd_o, m_addr_o);
    end
    tick();
    tick();
    #1;
    vec_cnt++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'b0001, 1'b0, 16'hA5A5}) begin
      err_cnt++;
      $display("FAIL rd_rsp: got %b/%b/%h want 0001/0/a5a5", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    tick();
    #1;
    vec_cnt++;
    if ({rsp_valid_o, rsp_rdata_o} !== {4'b0000, 16'hA5A5}) begin
      err_cnt++;
      $display("FAIL rd_hold: got %b/%h want 0000/a5a5", rsp_valid_o, rsp_rdata_o);
    end
  endtask

  task automatic test_all_four();
    apply_reset();
    tick();
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 8'(k + 1), 16'h0000);
    req_valid_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      vec_cnt++;
      if (req_ready_o !== 4'(1 << k)) begin
        err_cnt++;
        $display("FAIL all4_grant%0d: got %b want %b", k, req_ready_o, 4'(1 << k));
      end
      tick();
      req_valid_i[k] = 1'b0;
      tick();
      tick();
      #1;
      vec_cnt++;
      if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'(1 << k), 1'b0, 8'(k + 1), 8'(k + 1)}) begin
        err_cnt++;
        $display("FAIL all4_rsp%0d: got %b/%b/%h", k, rsp_valid_o, rsp_err_o, rsp_rdata_o);
      end
      tick();
    end
    req_valid_i = 4'b1001;
    #1;
    vec_cnt++;
    if (req_ready_o !== 4'b0001) begin
      err_cnt++;
      $display("FAIL all4_wrap: got %b want 0001", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_out_of_range();
    int mv0;
    mv0 = mv_cnt;
    set_req(2, 1'b1, 8'd64, 16'hBEEF);
    req_valid_i = 4'b0100;
    #1;
    vec_cnt++;
    if (req_ready_o !== 4'b0100) begin
      err_cnt++;
      $display("FAIL oor_accept: got %b want 0100", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    #1;
    vec_cnt++;
    if ({m_valid_o, rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {1'b0, 4'b0100, 1'b1, 16'h0000}) begin
      err_cnt++;
      $display("FAIL oor_rsp: got %b/%b/%b/%h want 0/0100/1/0000", m_valid_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    vec_cnt++;
    if (mv_cnt !== mv0) begin
      err_cnt++;
      $display("FAIL oor_no_access: got %0d slave accesses want %0d", mv_cnt, mv0);
    end
    tick();
    set_req(2, 1'b0, 8'd0, 16'h0000);
    req_valid_i = 4'b0100;
    tick();
    req_valid_i = '0;
    tick();
    tick();
    #1;
    vec_cnt++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'b0100, 1'b0, 16'h0000}) begin
      err_cnt++;
      $display("FAIL oor_mem_intact: got %b/%b/%h want 0100/0/0000", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    slave_en = 1'b0;
    set_req(1, 1'b0, 8'd3, 16'h0000);
    req_valid_i = 4'b0010;
    #1;
    vec_cnt++;
    if (req_ready_o !== 4'b0010) begin
      err_cnt++;
      $display("FAIL tmo_accept: got %b want 0010", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    repeat (TMO) tick();
    #1;
    vec_cnt++;
    if ({m_valid_o, rsp_valid_o} !== 5'b0) begin
      err_cnt++;
      $display("FAIL tmo_early: got %b/%b want 0/0000 in last wait cycle", m_valid_o, rsp_valid_o);
    end
    tick();
    #1;
    vec_cnt++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'b0010, 1'b1, 16'h0000}) begin
      err_cnt++;
      $display("FAIL tmo_rsp: got %b/%b/%h want 0010/1/0000", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    slave_en = 1'b1;
    tick();
    set_req(0, 1'b0, 8'd7, 16'h0000);
    set_req(2, 1'b0, 8'd9, 16'h0000);
    req_valid_i = 4'b0101;
    #1;
    vec_cnt++;
    if (req_ready_o !== 4'b0100) begin
      err_cnt++;
      $display("FAIL tmo_ptr_adv: got %b want 0100", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    tick();
    tick();
    #1;
    vec_cnt++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'b0100, 1'b0, 16'h0909}) begin
      err_cnt++;
      $display("FAIL tmo_recover: got %b/%b/%h want 0100/0/0909", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int rsp_seen;
    slave_en = 1'b0;
    set_req(1, 1'b0, 8'd2, 16'h0000);
    req_valid_i = 4'b0010;
    tick();
    req_valid_i = '0;
    tick();
    tick();
    #1;
    vec_cnt++;
    if ({m_valid_o, m_addr_o} !== {1'b0, 8'd2}) begin
      err_cnt++;
      $display("FAIL rst_wait_hold: got %b/%h want 0/02", m_valid_o, m_addr_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    vec_cnt++;
    if ({m_valid_o, m_addr_o, rsp_valid_o, rsp_err_o} !== 14'h0) begin
      err_cnt++;
      $display("FAIL rst_wait_async: got %b/%h/%b/%b want 0", m_valid_o, m_addr_o, rsp_valid_o, rsp_err_o);
    end
    tick();
    rst_ni   = 1'b1;
    slave_en = 1'b1;
    rsp_seen = 0;
    repeat (20) begin
      tick();
      if (rsp_valid_o != '0) rsp_seen++;
    end
    vec_cnt++;
    if (rsp_seen !== 0) begin
      err_cnt++;
      $display("FAIL rst_no_rsp: got %0d rsp cycles want 0", rsp_seen);
    end
    set_req(3, 1'b0, 8'd4, 16'h0000);
    set_req(1, 1'b0, 8'd6, 16'h0000);
    req_valid_i = 4'b1000;
    #1;
    vec_cnt++;
    if (req_ready_o !== 4'b1000) begin
      err_cnt++;
      $display("FAIL rst_only3: got %b want 1000", req_ready_o);
    end
    req_valid_i = 4'b1010;
    #1;
    vec_cnt++;
    if (req_ready_o !== 4'b0010) begin
      err_cnt++;
      $display("FAIL rst_ptr0: got %b want 0010", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    #1;
    vec_cnt++;
    if ({m_valid_o, m_addr_o} !== {1'b1, 8'd6}) begin
      err_cnt++;
      $display("FAIL rst_access: got %b/%h want 1/06", m_valid_o, m_addr_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    vec_cnt++;
    if ({m_valid_o, rsp_valid_o} !== 5'b0) begin
      err_cnt++;
      $display("FAIL rst_access_async: got %b/%b want 0/0000", m_valid_o, rsp_valid_o);
    end
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    tick();
    set_req(0, 1'b0, 8'd10, 16'h0000);
    set_req(1, 1'b0, 8'd11, 16'h0000);
    req_valid_i = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      exp = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      #1;
      vec_cnt++;
      if (req_ready_o !== exp) begin
        err_cnt++;
        $display("FAIL fair_grant%0d: got %b want %b", i, req_ready_o, exp);
      end
      tick();
      tick();
      tick();
      #1;
      vec_cnt++;
      if (rsp_valid_o !== exp) begin
        err_cnt++;
        $display("FAIL fair_rsp%0d: got %b want %b", i, rsp_valid_o, exp);
      end
      tick();
    end
    req_valid_i = '0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_all_four();
    test_out_of_range();
    test_timeout();
    test_reset_mid();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
